sub32_seq: RTL and testbench

SUB32_SEQ -- requirements
Module: sub32_seq

---
 rtl/sub32_seq.sv | 102 ++++++++++
 tb/tb_sub32_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub32_seq.sv
// rtl/sub32_seq.sv - digit-serial 32-bit subtractor with start/done handshakes
// Computes a - b - Bin as a + ~b + ~Bin, DIGIT_W bits per clock, LSB first.
module sub32_seq #(
  parameter int DIGIT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        Bin,
  input  logic        start_valid,
  output logic        start_ready,
  output logic [31:0] diff,
  output logic        Bout,
  output logic        done_valid,
  input  logic        done_ready
);

  localparam int N     = 32 / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [31:0]        r_acc;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic [5:0]         w_idx;
  logic [DIGIT_W-1:0] w_a_dig;
  logic [DIGIT_W-1:0] w_b_dig;
  logic [DIGIT_W:0]   w_sum;
  logic [31:0]        w_acc_next;
  logic               w_last;

  // Digit selection by index keeps the captured operands untouched during RUN.
  always_comb begin
    w_idx      = 6'(r_cnt) * 6'(DIGIT_W);
    w_a_dig    = r_a[w_idx +: DIGIT_W];
    w_b_dig    = r_b[w_idx +: DIGIT_W];
    w_sum      = {1'b0, w_a_dig} + {1'b0, ~w_b_dig} + {{DIGIT_W{1'b0}}, r_carry};
    w_acc_next = r_acc;
    w_acc_next[w_idx +: DIGIT_W] = w_sum[DIGIT_W-1:0];
    w_last     = (r_cnt == CNT_W'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      start_ready <= 1'b1;
      done_valid  <= 1'b0;
      diff        <= '0;
      Bout        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a         <= a;
            r_b         <= b;
            r_carry     <= ~Bin;
            r_cnt       <= '0;
            r_acc       <= '0;
            start_ready <= 1'b0;
            r_state     <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_sum[DIGIT_W];
          r_cnt   <= r_cnt + 1'b1;
          // The final carry out of a + ~b + ~Bin is the inverted borrow.
          if (w_last) begin
            diff       <= w_acc_next;
            Bout       <= ~w_sum[DIGIT_W];
            done_valid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid  <= 1'b0;
            start_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          done_valid  <= 1'b0;
          start_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub32_seq.sv
// tb/tb_sub32_seq.sv - bench for sub32_seq at DIGIT_W = 1, 4 and 32
// All three instances share operands and start; each has its own done_ready.
module tb_sub32_seq;

  logic             clk;
  logic             rst_n;
  logic [31:0]      a;
  logic [31:0]      b;
  logic             Bin;
  logic             start_valid;
  logic [2:0]       start_ready;
  logic [2:0][31:0] diff;
  logic [2:0]       Bout;
  logic [2:0]       done_valid;
  logic [2:0]       done_ready;

  int n_cmp;
  int n_err;
  int lat_exp [3] = '{32, 8, 1};

  int          obs_lat  [3];
  logic [31:0] obs_diff [3];
  logic        obs_bout [3];

  sub32_seq #(.DIGIT_W(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .Bin(Bin),
    .start_valid(start_valid), .start_ready(start_ready[0]),
    .diff(diff[0]), .Bout(Bout[0]), .done_valid(done_valid[0]), .done_ready(done_ready[0])
  );

  sub32_seq #(.DIGIT_W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .Bin(Bin),
    .start_valid(start_valid), .start_ready(start_ready[1]),
    .diff(diff[1]), .Bout(Bout[1]), .done_valid(done_valid[1]), .done_ready(done_ready[1])
  );

  sub32_seq #(.DIGIT_W(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .Bin(Bin),
    .start_valid(start_valid), .start_ready(start_ready[2]),
    .diff(diff[2]), .Bout(Bout[2]), .done_valid(done_valid[2]), .done_ready(done_ready[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
    return {1'b0, ma} - {1'b0, mb} - {32'b0, mbin};
  endfunction

  task automatic wait_done(input bit do_handshake);
    for (int i = 0; i < 3; i++) obs_lat[i] = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (done_valid[i] && obs_lat[i] == 0) begin
          obs_lat[i]  = cyc;
          obs_diff[i] = diff[i];
          obs_bout[i] = Bout[i];
        end
      end
      if (obs_lat[0] != 0 && obs_lat[1] != 0 && obs_lat[2] != 0) break;
    end
    if (do_handshake) begin
      done_ready = 3'b111;
      @(posedge clk);
      #1;
      done_ready = 3'b000;
    end
  endtask

  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic bini);
    a = ai;
    b = bi;
    Bin = bini;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    Bin = 1'($urandom);
    wait_done(1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    a = '0;
    b = '0;
    Bin = 1'b0;
    start_valid = 1'b0;
    done_ready = 3'b000;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if (start_ready !== 3'b111 || done_valid !== 3'b000 || Bout !== 3'b000 || diff !== '0) begin
      n_err++;
      $display("FAIL reset_state got sr=%b dv=%b bout=%b diff=%h exp sr=111 dv=000 bout=000 diff=0",
               start_ready, done_valid, Bout, diff);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [31:0] va [6] = '{32'd100, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] vb [6] = '{32'd0,   32'd1, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
    logic        vc [6] = '{1'b0,    1'b0,  1'b1,          1'b1,          1'b0,          1'b1};
    logic [32:0] ve [6] = '{{1'b0, 32'd100}, {1'b1, 32'hFFFF_FFFF}, {1'b0, 32'h7FFF_FFFF},
                            {1'b1, 32'hFFFF_FFFF}, {1'b0, 32'h0}, {1'b1, 32'hFFFF_FFFF}};
    for (int v = 0; v < 6; v++) begin
      run_op(va[v], vb[v], vc[v]);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs_lat[i] != lat_exp[i] || {obs_bout[i], obs_diff[i]} !== ve[v]) begin
          n_err++;
          $display("FAIL vector%0d inst=%0d got lat=%0d res=%h exp lat=%0d res=%h",
                   v, i, obs_lat[i], {obs_bout[i], obs_diff[i]}, lat_exp[i], ve[v]);
        end
        n_cmp++;
        if ({Bout[i], diff[i]} !== ve[v] || start_ready[i] !== 1'b1 || done_valid[i] !== 1'b0) begin
          n_err++;
          $display("FAIL vector%0d_hold inst=%0d got res=%h sr=%b dv=%b exp res=%h sr=1 dv=0",
                   v, i, {Bout[i], diff[i]}, start_ready[i], done_valid[i], ve[v]);
        end
      end
    end
  endtask

  task automatic test_stall;
    logic [32:0] exp1;
    logic [32:0] exp2;
    exp1 = model(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    exp2 = model(32'h0000_0005, 32'hA5A5_0000, 1'b0);
    a = 32'h1234_5678;
    b = 32'h0FED_CBA9;
    Bin = 1'b1;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    wait_done(1'b0);
    a = 32'h0000_0005;
    b = 32'hA5A5_0000;
    Bin = 1'b0;
    start_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (done_valid[i] !== 1'b1 || start_ready[i] !== 1'b0 || {Bout[i], diff[i]} !== exp1) begin
          n_err++;
          $display("FAIL stall c=%0d inst=%0d got dv=%b sr=%b res=%h exp dv=1 sr=0 res=%h",
                   c, i, done_valid[i], start_ready[i], {Bout[i], diff[i]}, exp1);
        end
      end
    end
    done_ready = 3'b111;
    @(posedge clk);
    #1;
    done_ready = 3'b000;
    n_cmp++;
    if (start_ready !== 3'b111 || done_valid !== 3'b000) begin
      n_err++;
      $display("FAIL stall_release got sr=%b dv=%b exp sr=111 dv=000", start_ready, done_valid);
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    n_cmp++;
    if (start_ready !== 3'b000) begin
      n_err++;
      $display("FAIL stall_accept got sr=%b exp sr=000", start_ready);
    end
    wait_done(1'b1);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs_lat[i] != lat_exp[i] || {obs_bout[i], obs_diff[i]} !== exp2) begin
        n_err++;
        $display("FAIL stall_new_op inst=%0d got lat=%0d res=%h exp lat=%0d res=%h",
                 i, obs_lat[i], {obs_bout[i], obs_diff[i]}, lat_exp[i], exp2);
      end
    end
  endtask

  task automatic test_early_ready;
    int          first [3];
    int          cnt   [3];
    logic [32:0] res   [3];
    logic [32:0] exp_r;
    exp_r = model(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
    for (int i = 0; i < 3; i++) begin
      first[i] = 0;
      cnt[i] = 0;
      res[i] = '0;
    end
    done_ready = 3'b111;
    a = 32'hDEAD_BEEF;
    b = 32'hCAFE_F00D;
    Bin = 1'b1;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (first[i] != 0 && cyc == first[i] + 1) begin
          n_cmp++;
          if (start_ready[i] !== 1'b1) begin
            n_err++;
            $display("FAIL early_ready_sr inst=%0d got sr=%b exp sr=1", i, start_ready[i]);
          end
        end
        if (done_valid[i]) begin
          cnt[i]++;
          if (first[i] == 0) begin
            first[i] = cyc;
            res[i] = {Bout[i], diff[i]};
          end
        end
      end
    end
    done_ready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (first[i] != lat_exp[i] || cnt[i] != 1 || res[i] !== exp_r) begin
        n_err++;
        $display("FAIL early_ready inst=%0d got lat=%0d dv_cycles=%0d res=%h exp lat=%0d dv_cycles=1 res=%h",
                 i, first[i], cnt[i], res[i], lat_exp[i], exp_r);
      end
    end
  endtask

  task automatic test_reset_abort;
    a = 32'd5;
    b = 32'd3;
    Bin = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (start_ready !== 3'b111 || done_valid !== 3'b000 || Bout !== 3'b000 || diff !== '0) begin
      n_err++;
      $display("FAIL abort_reset got sr=%b dv=%b bout=%b diff=%h exp sr=111 dv=000 bout=000 diff=0",
               start_ready, done_valid, Bout, diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (done_valid !== 3'b000 || start_ready !== 3'b111) begin
        n_err++;
        $display("FAIL abort_quiet c=%0d got dv=%b sr=%b exp dv=000 sr=111", c, done_valid, start_ready);
      end
    end
  endtask

  task automatic test_random_sweep;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [32:0] exp_r;
    for (int k = 0; k < 350; k++) begin
      if (k < 200) begin
        ra = $urandom_range(999, 0);
        rb = $urandom_range(999, 0);
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      rc = 1'($urandom);
      exp_r = model(ra, rb, rc);
      run_op(ra, rb, rc);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs_lat[i] != lat_exp[i] || {obs_bout[i], obs_diff[i]} !== exp_r) begin
          n_err++;
          $display("FAIL sweep k=%0d inst=%0d a=%h b=%h bin=%b got lat=%0d res=%h exp lat=%0d res=%h",
                   k, i, ra, rb, rc, obs_lat[i], {obs_bout[i], obs_diff[i]}, lat_exp[i], exp_r);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_vectors;
    test_stall;
    test_early_ready;
    test_reset_abort;
    test_random_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
